// File: rtl/grn_attractor_ctrl_if.sv
// Result port of the attractor sequencer: one record per initial state, valid/ready.
// The master holds every res_* field stable while res_valid is high and res_ready is low.
interface grn_attractor_ctrl_if #(
    parameter int N_NODES = 8,
    parameter int CNT_W   = 16
);
    logic               res_valid;
    logic               res_ready;
    logic [N_NODES-1:0] res_init;
    logic [CNT_W-1:0]   res_steps;
    logic [N_NODES-1:0] res_state;
    logic               res_timeout;

    modport master (
        output res_valid,
        output res_init,
        output res_steps,
        output res_state,
        output res_timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_init,
        input  res_steps,
        input  res_state,
        input  res_timeout,
        output res_ready
    );
endinterface

// File: rtl/grn_attractor_ctrl.sv
// GRN attractor sweep sequencer: load array, step s0/s1, report when vectors meet.
// Latency: start->LOAD 1 cycle, fixed point reported 5 cycles after start; stalls in REPORT until res_ready.
module grn_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N_NODES-1:0]   init_first,
    input  logic [CNT_W-1:0]     num_inits,
    output logic                 reset_nos,
    output logic [N_NODES-1:0]   init_state,
    output logic                 start_s0,
    output logic                 start_s1,
    input  logic [N_NODES-1:0]   s0_vec,
    input  logic [N_NODES-1:0]   s1_vec,
    grn_attractor_ctrl_if.master res,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_REPORT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]         state;
    logic [N_NODES-1:0] cur_init;
    logic [CNT_W-1:0]   num_lat;
    logic [CNT_W-1:0]   k;
    logic [CNT_W-1:0]   step_cnt;

    logic [N_NODES-1:0] res_init_q;
    logic [CNT_W-1:0]   res_steps_q;
    logic [N_NODES-1:0] res_state_q;
    logic               res_timeout_q;

    logic match;
    logic at_limit;
    logic last_init;

    // s0 lags s1 by half the steps, so equality from step 2 onward means a cycle was closed.
    assign match     = (step_cnt >= CNT_W'(2)) && (s0_vec == s1_vec);
    assign at_limit  = (step_cnt == CNT_W'(MAX_STEPS));
    assign last_init = (k == (num_lat - CNT_W'(1)));

    assign reset_nos  = (state == ST_LOAD);
    assign init_state = reset_nos ? cur_init : '0;
    assign start_s0   = (state == ST_RUN) && !match && !at_limit && !abort;
    assign start_s1   = start_s0;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    assign res.res_valid   = (state == ST_REPORT);
    assign res.res_init    = res_init_q;
    assign res.res_steps   = res_steps_q;
    assign res.res_state   = res_state_q;
    assign res.res_timeout = res_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cur_init      <= '0;
            num_lat       <= '0;
            k             <= '0;
            step_cnt      <= '0;
            res_init_q    <= '0;
            res_steps_q   <= '0;
            res_state_q   <= '0;
            res_timeout_q <= 1'b0;
        end else if (abort) begin
            state         <= ST_IDLE;
            k             <= '0;
            step_cnt      <= '0;
            res_init_q    <= '0;
            res_steps_q   <= '0;
            res_state_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_init <= init_first;
                        num_lat  <= num_inits;
                        k        <= '0;
                        state    <= (num_inits == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    step_cnt <= '0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (match || at_limit) begin
                        res_init_q    <= cur_init;
                        res_steps_q   <= step_cnt;
                        res_state_q   <= s1_vec;
                        res_timeout_q <= !match;
                        state         <= ST_REPORT;
                    end else begin
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (res.res_ready) begin
                        if (last_init) begin
                            state <= ST_DONE;
                        end else begin
                            k        <= k + CNT_W'(1);
                            cur_init <= cur_init + N_NODES'(1);
                            state    <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Directed bench for grn_attractor_ctrl with a behavioural two-stream node array.
module tb_grn_attractor_ctrl;
    localparam int N  = 8;
    localparam int W  = 16;
    localparam int MS = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] init_first = '0;
    logic [W-1:0] num_inits = '0;
    logic         reset_nos, start_s0, start_s1, busy, done;
    logic [N-1:0] init_state;
    logic [N-1:0] s0_vec, s1_vec;
    logic         par;

    grn_attractor_ctrl_if #(.N_NODES(N), .CNT_W(W)) rif ();

    grn_attractor_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(MS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .init_first (init_first),
        .num_inits  (num_inits),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start_s0   (start_s0),
        .start_s1   (start_s1),
        .s0_vec     (s0_vec),
        .s1_vec     (s1_vec),
        .res        (rif),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // 0: fixed point, 1: 0->1->2->0 cycle, 2: non-repeating counter
    int mode = 0;

    function automatic logic [N-1:0] fmap(input logic [N-1:0] x);
        if (mode == 0) return x;
        if (mode == 1) return (x == 8'd0) ? 8'd1 : (x == 8'd1) ? 8'd2 : (x == 8'd2) ? 8'd0 : x;
        return x + 8'd1;
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            par    <= 1'b0;
        end else if (start_s1) begin
            s1_vec <= fmap(s1_vec);
            if (!par) s0_vec <= fmap(s0_vec);
            par <= ~par;
        end
    end

    int strobes = 0;
    int viol = 0;
    always @(posedge clk) begin
        if (start_s0) strobes++;
        if ((start_s0 !== start_s1) || (start_s0 && reset_nos)) viol++;
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input logic [N-1:0] init, input logic [W-1:0] num);
        init_first = init;
        num_inits  = num;
        start      = 1'b1;
        cyc        = 0;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_valid(input int max, output logic ok);
        int i;
        i = 0;
        while (!rif.res_valid && i < max) begin
            step();
            i++;
        end
        ok = rif.res_valid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         ok;
        int           nres, ndone, res_at_done, bad, s;
        logic [N-1:0] got [4];

        rif.res_ready = 1'b1;
        step();
        step();
        check("rst_reset_nos", reset_nos, 0);
        check("rst_start_s0", start_s0, 0);
        check("rst_res_valid", rif.res_valid, 0);
        check("rst_res_steps", rif.res_steps, 0);
        check("rst_busy_done", {busy, done}, 0);
        rst_n = 1'b1;
        step();

        // Fixed point 5A: strobes at cycles 2,3, match at 4, result at 5, done at 6
        mode = 0;
        go(8'h5A, 1);
        check("fp_load", {reset_nos, init_state}, {1'b1, 8'h5A});
        step();
        check("fp_strobe_c2", start_s0, 1);
        step();
        step();
        check("fp_no_strobe_c4", start_s0, 0);
        step();
        check("fp_valid_c5", rif.res_valid, 1);
        check("fp_steps", rif.res_steps, 2);
        check("fp_state", rif.res_state, 8'h5A);
        check("fp_init_to", {rif.res_init, rif.res_timeout}, {8'h5A, 1'b0});
        step();
        check("fp_done_c6", done, 1);
        step();
        check("fp_idle", {busy, done}, 0);

        // 0->1->2->0: s0=x[ceil(t/2)], s1=x[t] first agree at t=6 (x3==x6==0)
        mode = 1;
        go(8'h00, 1);
        wait_valid(40, ok);
        check("p3_valid", ok, 1);
        check("p3_latency", cyc, 9);
        check("p3_steps", rif.res_steps, 6);
        check("p3_state", rif.res_state, 8'h00);
        check("p3_timeout", rif.res_timeout, 0);
        step();
        step();

        // Sweep of three with wrap FE, FF, 00
        mode = 0;
        nres = 0;
        ndone = 0;
        res_at_done = -1;
        go(8'hFE, 3);
        for (int i = 0; i < 40; i++) begin
            if (rif.res_valid) begin
                if (nres < 4) got[nres] = rif.res_init;
                nres++;
            end
            if (done) begin
                ndone++;
                res_at_done = nres;
            end
            step();
        end
        check("sw_nres", nres, 3);
        check("sw_init0", got[0], 8'hFE);
        check("sw_init1", got[1], 8'hFF);
        check("sw_init2", got[2], 8'h00);
        check("sw_ndone", ndone, 1);
        check("sw_done_after_last", res_at_done, 3);

        // Back-pressure: result held, no strobes, LOAD right after release
        rif.res_ready = 1'b0;
        go(8'h33, 2);
        wait_valid(20, ok);
        check("bp_valid", ok, 1);
        s = strobes;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!rif.res_valid || rif.res_steps !== 16'd2 || rif.res_init !== 8'h33 ||
                rif.res_state !== 8'h33 || reset_nos !== 1'b0) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_no_strobes", strobes - s, 0);
        rif.res_ready = 1'b1;
        step();
        check("bp_next_load", {reset_nos, init_state}, {1'b1, 8'h34});
        wait_valid(20, ok);
        check("bp_second_init", {ok, rif.res_init}, {1'b1, 8'h34});
        step();
        check("bp_done", done, 1);
        step();

        // Timeout with a counter map
        mode = 2;
        s = strobes;
        go(8'h10, 1);
        wait_valid(40, ok);
        check("to_valid", ok, 1);
        check("to_latency", cyc, MS + 3);
        check("to_flag", rif.res_timeout, 1);
        check("to_steps", rif.res_steps, MS);
        check("to_state", rif.res_state, 8'h20);
        step();
        check("to_strobe_count", strobes - s, MS);
        step();

        // Empty sweep
        go(8'h44, 0);
        check("empty_done", {done, rif.res_valid, reset_nos}, 3'b100);
        step();
        check("empty_idle", {busy, done}, 0);

        // Abort mid-RUN
        mode = 2;
        go(8'h00, 1);
        repeat (4) step();
        check("ab_running", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_idle", {busy, start_s0, rif.res_valid, done}, 0);
        check("ab_res_cleared", rif.res_steps, 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) ndone++;
        end
        check("ab_no_done", ndone, 0);
        mode = 0;
        go(8'h77, 1);
        wait_valid(20, ok);
        check("ab_restart", {ok, rif.res_init, rif.res_steps}, {1'b1, 8'h77, 16'd2});
        check("ab_restart_lat", cyc, 5);
        step();
        step();

        // Asynchronous reset mid-RUN
        mode = 2;
        go(8'h00, 1);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("rs_async", {busy, start_s0, reset_nos, rif.res_valid}, 0);
        step();
        rst_n = 1'b1;
        step();
        mode = 1;
        go(8'h00, 1);
        wait_valid(40, ok);
        check("rs_restart", {ok, rif.res_steps}, {1'b1, 16'd6});
        step();
        step();

        check("strobe_rules", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
